// File: rtl/register_file_sb.sv
// Multi-port register file with optional write-to-read bypass, a per-register busy
// scoreboard for ID-stage hazard detection, a debug read port and a committed-write counter.
module register_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int N_RD   = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_RD*ADDR_W-1:0]   ra,
    output logic [N_RD*DATA_W-1:0]   rd,
    output logic [N_RD-1:0]          rbusy,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic [ADDR_W-1:0]        dra,
    output logic [DATA_W-1:0]        drd,
    output logic [31:0]              wr_cnt
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [31:0]       wr_cnt_q;
    logic [31:0]       wr_cnt_d;

    logic wr_commit;

    // Register 0 is hardwired: writes to it never commit and never count.
    assign wr_commit = we && (wa != '0);

    always_comb begin
        rf_d     = rf_q;
        busy_d   = busy_q;
        wr_cnt_d = wr_cnt_q;
        if (wr_commit) begin
            rf_d[wa] = wd;
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
        if (we) begin
            busy_d[wa] = 1'b0;
        end
        // Applied after the clear so a newly issued producer supersedes the retiring one.
        if (set_en && (set_addr != '0)) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_q     <= '{default: '0};
            busy_q   <= '0;
            wr_cnt_q <= '0;
        end else begin
            rf_q     <= rf_d;
            busy_q   <= busy_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra_i;
        logic [DATA_W-1:0] rd_i;
        logic              hit_i;

        assign ra_i  = ra[i*ADDR_W +: ADDR_W];
        assign hit_i = BYPASS && wr_commit && (wa == ra_i);

        always_comb begin
            rd_i = '0;
            if (ra_i != '0) begin
                rd_i = hit_i ? wd : rf_q[ra_i];
            end
        end

        assign rd[i*DATA_W +: DATA_W] = rd_i;
        assign rbusy[i] = (ra_i != '0) && busy_q[ra_i];
    end

    assign drd    = (dra != '0) ? rf_q[dra] : '0;
    assign wr_cnt = wr_cnt_q;

endmodule
